// File: rtl/types_pkg.sv
// Shared types for the experiment-phase front end: channel indices, the clean
// input bundle handed to the scenario FSM, and the per-channel conditioner state.
package types_pkg;

    localparam int NUM_IN_CH    = 5;
    localparam int CH_START     = 0;
    localparam int CH_FG        = 1;
    localparam int CH_PHASE     = 2;
    localparam int CH_WIRE      = 3;
    localparam int CH_DET_READY = 4;

    // Field order puts start_signal in bit 0 so the packed value lines up with raw_in.
    typedef struct packed {
        logic detector_ready;
        logic wire_signal;
        logic phase_signal;
        logic fg_signal;
        logic start_signal;
    } input_signals_t;

    typedef enum logic [1:0] {
        STABLE  = 2'd0,
        QUALIFY = 2'd1,
        HOLDOFF = 2'd2
    } cond_state_t;

endpackage

// File: rtl/input_filter_channel.sv
// One conditioned input: synchroniser, glitch filter, hold-off, edge strobes, counter, glitch flag.
// Latency SYNC_STAGES + FILTER_LEN cycles from pin to level; no backpressure, runs every cycle.
module input_filter_channel
    import types_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int HOLDOFF_LEN = 200,
    parameter int CNT_W       = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             raw_i,
    input  logic             count_clear_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] count_o,
    output logic             glitch_o
);

    localparam int QW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int HW = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
    localparam logic [QW-1:0] QUAL_LAST = QW'(FILTER_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    cond_state_t            state_q, state_d;
    logic [QW-1:0]          qual_q, qual_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   glitch_q, glitch_d;
    logic                   sample;
    logic                   accept;
    logic                   abort;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        hold_d  = hold_q;
        level_d = level_q;
        accept  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            STABLE: begin
                if (sample != level_q) begin
                    if (FILTER_LEN == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        qual_d  = QW'(1);
                    end
                end
            end
            QUALIFY: begin
                if (sample == level_q) begin
                    abort   = 1'b1;
                    state_d = STABLE;
                    qual_d  = '0;
                end else if (qual_q == QUAL_LAST) begin
                    accept = 1'b1;
                end else begin
                    qual_d = qual_q + 1'b1;
                end
            end
            HOLDOFF: begin
                // Sample is deliberately ignored here; a lingering mismatch requalifies from STABLE.
                if (hold_q == HOLD_LAST) begin
                    state_d = STABLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
            end
        endcase
        if (accept) begin
            level_d = ~level_q;
            qual_d  = '0;
            hold_d  = '0;
            state_d = (HOLDOFF_LEN == 0) ? STABLE : HOLDOFF;
        end
    end

    assign rise_d = accept & ~level_q;
    assign fall_d = accept &  level_q;

    // A clear that lands on a visible rising strobe still records that edge.
    always_comb begin
        count_d = count_q;
        if (count_clear_i) begin
            count_d = {{(CNT_W-1){1'b0}}, rise_q};
        end else if (rise_q && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    assign glitch_d = abort | (glitch_q & ~count_clear_i);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q   <= '0;
            state_q  <= STABLE;
            qual_q   <= '0;
            hold_q   <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            count_q  <= '0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            qual_q   <= qual_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            count_q  <= count_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign count_o  = count_q;
    assign glitch_o = glitch_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the five raw experiment pins into a clean input_signals_t bundle plus status.
// Latency SYNC_STAGES + FILTER_LEN cycles pin-to-level; no backpressure, channels independent.
module input_conditioner
    import types_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter int                   FILTER_LEN  = 8,
    parameter int                   HOLDOFF_LEN = 200,
    parameter logic [NUM_IN_CH-1:0] INVERT_MASK = 5'b00000,
    parameter int                   CNT_W       = 16
) (
    input  logic                         clock,
    input  logic                         reset_signal,
    input  logic [NUM_IN_CH-1:0]         raw_in,
    input  logic                         count_clear,
    output input_signals_t               out,
    output logic [NUM_IN_CH-1:0]         rise_pulse,
    output logic [NUM_IN_CH-1:0]         fall_pulse,
    output logic [NUM_IN_CH*CNT_W-1:0]   edge_count,
    output logic [NUM_IN_CH-1:0]         glitch_seen
);

    logic [NUM_IN_CH-1:0] raw_pol;
    logic [NUM_IN_CH-1:0] level;

    // Polarity is normalised ahead of the synchroniser so every channel filters active-high.
    assign raw_pol = raw_in ^ INVERT_MASK;

    for (genvar ch = 0; ch < NUM_IN_CH; ch++) begin : g_ch
        input_filter_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .HOLDOFF_LEN (HOLDOFF_LEN),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clock_i       (clock),
            .reset_i       (reset_signal),
            .raw_i         (raw_pol[ch]),
            .count_clear_i (count_clear),
            .level_o       (level[ch]),
            .rise_o        (rise_pulse[ch]),
            .fall_o        (fall_pulse[ch]),
            .count_o       (edge_count[ch*CNT_W +: CNT_W]),
            .glitch_o      (glitch_seen[ch])
        );
    end

    always_comb begin
        out                = '0;
        out.start_signal   = level[CH_START];
        out.fg_signal      = level[CH_FG];
        out.phase_signal   = level[CH_PHASE];
        out.wire_signal    = level[CH_WIRE];
        out.detector_ready = level[CH_DET_READY];
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a window-based reference model checked every cycle.
module tb_input_conditioner;
    import types_pkg::*;

    localparam int          SYNC = 2;
    localparam int          FL   = 8;
    localparam int          HL   = 200;
    localparam logic [4:0]  MASK = 5'b10000;
    localparam int          CW   = 4;
    localparam logic [31:0] WMASK = (32'd1 << FL) - 32'd1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic              clock = 1'b0;
    logic              reset_signal;
    logic [4:0]        raw_in;
    logic              count_clear;
    input_signals_t    out_s;
    logic [4:0]        rise_pulse, fall_pulse, glitch_seen;
    logic [5*CW-1:0]   edge_count;
    logic [4:0]        out_bits;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FL),
        .HOLDOFF_LEN (HL),
        .INVERT_MASK (MASK),
        .CNT_W       (CW)
    ) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .raw_in       (raw_in),
        .count_clear  (count_clear),
        .out          (out_s),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .edge_count   (edge_count),
        .glitch_seen  (glitch_seen)
    );

    assign out_bits = out_s;

    always #5 clock = ~clock;

    // Reference model: a channel accepts once the last FL samples seen while free all disagree.
    logic [SYNC-1:0]  m_pipe [5];
    logic [31:0]      m_hist [5];
    int               m_free [5];
    int               m_hold [5];
    logic [CW-1:0]    m_cnt  [5];
    logic [4:0]       m_filt, m_rise, m_fall, m_glitch;
    bit               model_valid = 1'b0;

    always @(posedge clock) begin
        logic        samp, acc, gl;
        logic [31:0] mm;
        logic [4:0]  mask_v;
        mask_v = MASK;
        if (reset_signal) begin
            for (int n = 0; n < 5; n++) begin
                m_pipe[n] = '0; m_hist[n] = '0; m_free[n] = 0; m_hold[n] = 0; m_cnt[n] = '0;
            end
            m_filt = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
            model_valid = 1'b1;
        end else begin
            for (int n = 0; n < 5; n++) begin
                samp = m_pipe[n][SYNC-1];
                m_pipe[n] = {m_pipe[n][SYNC-2:0], raw_in[n] ^ mask_v[n]};
                if (count_clear)
                    m_cnt[n] = m_rise[n] ? CW'(1) : CW'(0);
                else if (m_rise[n] && m_cnt[n] != CNT_MAX)
                    m_cnt[n] = m_cnt[n] + CW'(1);
                acc = 1'b0;
                gl  = 1'b0;
                if (m_hold[n] > 0) begin
                    m_hold[n] = m_hold[n] - 1;
                    m_free[n] = 0;
                end else begin
                    m_hist[n] = {m_hist[n][30:0], samp};
                    m_free[n] = m_free[n] + 1;
                    mm = m_filt[n] ? ~m_hist[n] : m_hist[n];
                    if (m_free[n] >= FL && (mm & WMASK) == WMASK)
                        acc = 1'b1;
                    else if (samp == m_filt[n] && m_free[n] >= 2 && m_hist[n][1] != m_filt[n])
                        gl = 1'b1;
                end
                m_rise[n] = acc & ~m_filt[n];
                m_fall[n] = acc &  m_filt[n];
                if (acc) begin
                    m_filt[n] = ~m_filt[n];
                    m_hold[n] = HL;
                    m_free[n] = 0;
                end
                m_glitch[n] = gl | (m_glitch[n] & ~count_clear);
            end
        end
    end

    always @(negedge clock) begin
        logic [39:0] act, exp_v;
        logic [5*CW-1:0] exp_cnt;
        if (model_valid) begin
            for (int n = 0; n < 5; n++) exp_cnt[n*CW +: CW] = m_cnt[n];
            act   = {out_bits, rise_pulse, fall_pulse, edge_count, glitch_seen};
            exp_v = {m_filt, m_rise, m_fall, exp_cnt, m_glitch};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL model_compare t=%0t got %h expected %h", $time, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic wait_level(input int ch, input logic val, input int limit, output int lat);
        lat = limit;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (out_bits[ch] === val) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ev_t [16];
        bit ev_r [16];
        int n_ev, min_gap, bad_alt;

        raw_in       = '0;
        count_clear  = 1'b0;
        reset_signal = 1'b1;
        tick(3);

        // Inverted detector_ready held low through reset surfaces as a clean rise.
        reset_signal = 1'b0;
        wait_level(CH_DET_READY, 1'b1, 40, lat);
        check("det_latency", lat, 10);
        check("det_rise_pulse", rise_pulse[CH_DET_READY], 1);
        @(negedge clock);
        check("det_rise_gone", rise_pulse[CH_DET_READY], 0);
        check("det_count", edge_count[CH_DET_READY*CW +: CW], 1);

        tick(1);
        raw_in[CH_FG] = 1'b1;
        wait_level(CH_FG, 1'b1, 40, lat);
        check("fg_latency", lat, 10);
        check("fg_rise_pulse", rise_pulse[CH_FG], 1);
        @(negedge clock);
        check("fg_rise_gone", rise_pulse[CH_FG], 0);
        check("fg_count", edge_count[CH_FG*CW +: CW], 1);
        tick(60);

        raw_in[CH_PHASE] = 1'b1; tick(3);
        raw_in[CH_PHASE] = 1'b0; tick(20);
        raw_in[CH_PHASE] = 1'b1; tick(7);
        raw_in[CH_PHASE] = 1'b0; tick(20);
        check("phase_glitch", glitch_seen[CH_PHASE], 1);
        check("phase_count0", edge_count[CH_PHASE*CW +: CW], 0);
        check("phase_level0", out_bits[CH_PHASE], 0);
        raw_in[CH_PHASE] = 1'b1; tick(8);
        raw_in[CH_PHASE] = 1'b0;
        wait_level(CH_PHASE, 1'b1, 20, lat);
        check("phase_8cyc_accept", lat, 2);
        tick(230);

        n_ev = 0;
        for (int c = 0; c < 1000; c++) begin
            if (c % 20 == 0) raw_in[CH_WIRE] = ~raw_in[CH_WIRE];
            @(negedge clock);
            if ((rise_pulse[CH_WIRE] || fall_pulse[CH_WIRE]) && n_ev < 16) begin
                ev_t[n_ev] = c;
                ev_r[n_ev] = rise_pulse[CH_WIRE];
                n_ev++;
            end
            tick(1);
        end
        raw_in[CH_WIRE] = 1'b0;
        min_gap = 1000000;
        bad_alt = 0;
        for (int i = 0; i < n_ev; i++) begin
            if (ev_r[i] != ((i % 2) == 0)) bad_alt++;
            if (i > 0 && ev_t[i] - ev_t[i-1] < min_gap) min_gap = ev_t[i] - ev_t[i-1];
        end
        check("wire_events", n_ev, 5);
        check("wire_min_gap_ok", (min_gap >= HL + FL) ? 1 : 0, 1);
        check("wire_alternation_errors", bad_alt, 0);
        tick(450);

        for (int i = 0; i < 20; i++) begin
            raw_in[CH_START] = 1'b1; tick(12);
            raw_in[CH_START] = 1'b0; tick(420);
        end
        check("start_saturated", edge_count[CH_START*CW +: CW], 15);
        raw_in[CH_START] = 1'b1;
        wait_level(CH_START, 1'b1, 40, lat);
        check("start_rise_seen", rise_pulse[CH_START], 1);
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        check("clear_keeps_edge", edge_count[CH_START*CW +: CW], 1);
        check("clear_glitch_flags", glitch_seen, 0);
        check("clear_fg_count", edge_count[CH_FG*CW +: CW], 0);
        raw_in[CH_START] = 1'b0;
        tick(450);

        // Every channel mid-qualification, then reset.
        raw_in = ~raw_in;
        tick(5);
        reset_signal = 1'b1;
        tick(1);
        check("rstq_levels", out_bits, 0);
        check("rstq_strobes", {rise_pulse, fall_pulse}, 0);
        check("rstq_counts", edge_count, 0);
        check("rstq_glitch", glitch_seen, 0);
        tick(2);
        reset_signal = 1'b0;
        tick(11);
        check("pre_hold_levels", out_bits, 5'b01101);
        reset_signal = 1'b1;
        tick(1);
        check("rsth_levels", out_bits, 0);
        check("rsth_strobes", {rise_pulse, fall_pulse}, 0);
        check("rsth_counts", edge_count, 0);
        tick(2);
        check("rsth_no_late_strobe", {rise_pulse, fall_pulse}, 0);
        reset_signal = 1'b0;
        tick(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
